// File: rtl/reduce_serial.sv
// ---------------------------------------------------------------------------
// reduce_serial
//
// Serial bit-vector reducer. A COUNT_OF_BITS-wide vector and a 3-bit operator
// code are accepted over a valid/ready handshake. The vector is then folded
// BITS_PER_CYCLE bits per clock into a single accumulator bit. The finalised
// bit is presented over a second valid/ready handshake.
//
// Handshake semantics (both sides): a transfer happens on the rising clock
// edge where valid && ready are both high. A producer must hold its data
// stable while valid is high and ready is low. A consumer may assert ready
// at any time, because ready has no effect while valid is low.
//
// Operator codes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 IMP (b -> acc, left
// fold from bit 0). Codes 6 and 7 are reserved and always produce 0.
//
// Parameters:
//   COUNT_OF_BITS   width of the input vector (>= 2)
//   BITS_PER_CYCLE  bits folded per RUN cycle (1 .. COUNT_OF_BITS-1)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   bitvector/op valid
//   in_ready   block can accept (high only in IDLE)
//   bitvector  vector to reduce
//   op         operator code
//   out_valid  reduce holds a final result
//   out_ready  consumer accepts the result
//   reduce     registered result bit
//   busy       high in RUN or DONE
//   fsm_state  current FSM state (0 IDLE, 1 RUN, 2 DONE), for observation
//   done_count 16-bit saturating count of output handshakes; present only
//              when REDUCE_SERIAL_STATS_EN is defined
//
// Optional feature macro: REDUCE_SERIAL_STATS_EN
// ---------------------------------------------------------------------------
module reduce_serial #(
    parameter int COUNT_OF_BITS  = 4,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COUNT_OF_BITS-1:0] bitvector,
    input  logic [2:0]               op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     reduce,
    output logic                     busy,
    output logic [1:0]               fsm_state
`ifdef REDUCE_SERIAL_STATS_EN
    ,
    output logic [15:0]              done_count
`endif
);

    // Index must be able to hold COUNT_OF_BITS-1 plus a chunk step.
    localparam int IDX_W = $clog2(COUNT_OF_BITS) + 1;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_IMP  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q;
    logic [COUNT_OF_BITS-1:0] vec_q;
    logic [2:0]               op_q;
    logic                     acc_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     out_valid_q;
    logic                     reduce_q;

    logic                     acc_next;
    logic                     last_chunk;
    logic [COUNT_OF_BITS-1:0] chunk;

    // One fold step. NAND/NOR fold like AND/OR; their inversion is applied
    // once to the final value, never per stage.
    function automatic logic fold_bit(input logic [2:0] code,
                                      input logic       acc,
                                      input logic       b);
        logic r;
        case (code)
            OP_AND, OP_NAND: r = acc & b;
            OP_OR,  OP_NOR:  r = acc | b;
            OP_XOR:          r = acc ^ b;
            OP_IMP:          r = ~b | acc;
            default:         r = acc;
        endcase
        return r;
    endfunction

    function automatic logic finalize(input logic [2:0] code,
                                      input logic       acc);
        logic r;
        case (code)
            OP_AND, OP_OR, OP_XOR, OP_IMP: r = acc;
            OP_NAND, OP_NOR:               r = ~acc;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

    // Fold the current chunk in ascending bit order. The captured vector is
    // shifted so the chunk's first bit sits at position 0. Bits at or beyond
    // COUNT_OF_BITS in a partial last chunk are masked and never folded.
    always_comb begin
        acc_next = acc_q;
        chunk    = vec_q >> idx_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if ((int'(idx_q) + k) < COUNT_OF_BITS) begin
                acc_next = fold_bit(op_q, acc_next, chunk[0]);
            end
            chunk = chunk >> 1;
        end
    end

    // This edge folds bit COUNT_OF_BITS-1 when the chunk reaches the top.
    assign last_chunk = (int'(idx_q) + BITS_PER_CYCLE) >= COUNT_OF_BITS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            op_q        <= '0;
            acc_q       <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            reduce_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // in_ready is high in IDLE, so in_valid alone is a transfer.
                    if (in_valid) begin
                        vec_q   <= bitvector;
                        op_q    <= op;
                        acc_q   <= bitvector[0];
                        idx_q   <= IDX_W'(1);
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_next;
                    if (last_chunk) begin
                        idx_q       <= '0;
                        reduce_q    <= finalize(op_q, acc_next);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(BITS_PER_CYCLE);
                    end
                end
                S_DONE: begin
                    // reduce_q is left untouched so the result stays stable.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_valid = out_valid_q;
    assign reduce    = reduce_q;
    assign fsm_state = state_q;

`ifdef REDUCE_SERIAL_STATS_EN
    logic [15:0] done_count_q;

    // Saturating count of completed output handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_count_q <= '0;
        end else if (out_valid_q && out_ready && (done_count_q != 16'hFFFF)) begin
            done_count_q <= done_count_q + 16'd1;
        end
    end

    assign done_count = done_count_q;
`endif

endmodule
